fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Fetch sequencer for the 9-bit instruction ROM. Owns the program counter.
//  Drives the ROM address and captures the combinational ROM output into a
//  registered instruction slot. Hands instructions to decode with a
//  valid/ready handshake, applies branch redirects, detects the halt word
//  and reports program completion plus a run-cycle count to the top level.
// PARAMETERS
//  A          10          ROM address width (PC width)
//  W          9           instruction width
//  START_ADDR 0           PC value loaded on reset and on Start
//  HALT_WORD  9'h1FF      encoding of the halt instruction
//  CW         16          width of CycleCnt
// PORTS
//  Clk          in   1   single clock, rising edge
//  Reset        in   1   synchronous, active-high
//  Start        in   1   one-cycle pulse that begins/restarts program execution
//  InstAddress  out  A   ROM address; always equals ProgCtr
//  InstIn       in   W   ROM data for InstAddress (combinational, same cycle)
//  Inst         out  W   registered instruction presented to decode
//  InstValid    out  1   Inst holds a live instruction
//  InstReady    in   1   decode consumes Inst this cycle (fire = InstValid & InstReady)
//  InstPC       out  A   address Inst was fetched from
//  BranchEn     in   1   valid only on fire; consumed Inst is a taken branch
//  BranchRel    in   1   1: target = InstPC + sext(BranchTarget); 0: absolute
//  BranchTarget in   A   absolute address or two's-complement offset
//  ProgCtr      out  A   current PC
//  Done         out  1   sticky; halt word consumed by decode
//  CycleCnt     out  CW  cycles spent in RUN+DRAIN since last Start; saturates
// BEHAVIOUR
//  Reset: state=IDLE, ProgCtr=START_ADDR, Inst=0, InstPC=0, InstValid=0,
//    Done=0, CycleCnt=0. Reset beats every other input, including mid-run.
//  States: IDLE, RUN, DRAIN, DONE.
//  IDLE: no fetch. On Start -> RUN. ProgCtr stays START_ADDR.
//  RUN: a fetch happens when (!InstValid | InstReady):
//    Inst<=InstIn, InstPC<=ProgCtr, InstValid<=1, ProgCtr<=ProgCtr+1 mod 2^A
//    (2^A-1 wraps to 0). Otherwise (stall) Inst, InstPC, ProgCtr and
//    InstValid hold.
//    If the fetched InstIn==HALT_WORD, go to DRAIN.
//  Branch: on fire with BranchEn=1:
//    ProgCtr<=target, computed mod 2^A; relative mode sign-extends BranchTarget.
//    InstValid<=0, which squashes the same-cycle fetch.
//    Stay in or return to RUN, even if the squashed word was HALT_WORD.
//    BranchEn is ignored when there is no fire.
//  DRAIN: no fetch; ProgCtr holds. On fire of the halt word:
//    InstValid<=0, Done<=1, go to DONE.
//  DONE: InstValid=0, Done=1. On Start:
//    ProgCtr<=START_ADDR, Done<=0, CycleCnt<=0, go to RUN.
//  Start in RUN or DRAIN is ignored.
//  Latency: Start at cycle t. InstAddress=START_ADDR during t+1.
//    Inst/InstValid are visible at t+2.
//  Throughput: with InstReady held high, one instruction per cycle.
//  A taken branch costs one bubble cycle.
//  CycleCnt: increments each cycle in RUN or DRAIN and stops at 2^CW-1.
//    It holds in IDLE and DONE. Start from IDLE also clears it.
// STRUCTURE
//  fetch_pkg: typedef enum logic[1:0] {IDLE,RUN,DRAIN,DONE} fetch_state_t;
//    default HALT_WORD constant.
//  Sub-module prog_ctr: PC register plus next-PC mux (hold / +1 / abs / rel /
//    START_ADDR). fetch_ctrl holds the FSM, instruction slot and counter.
//  The ROM is instantiated beside this block at top level:
//    InstAddress -> ROM, ROM InstOut -> InstIn.
// TESTING
//  1 ROM {0:9'h001,1:9'h002,2:HALT}, InstReady=1, Start at t ->
//    Inst 001/002/1FF at t+2..t+4. Done=1 at t+5. CycleCnt=4 after Done.
//  2 Same program, InstReady low for 3 cycles after first valid ->
//    Inst stays 001, ProgCtr stays 1, no word dropped or duplicated.
//  3 Fire at InstPC=5 with BranchEn=1, BranchRel=1, BranchTarget=10'h3FE ->
//    next InstPC=3, one bubble cycle, squashed word never valid.
//  4 Fire with absolute target 10'h3FF and no branch at 3FF ->
//    next InstPCs are 3FF then 000 (wrap).
//  5 Branch fires on the same cycle HALT is fetched ->
//    HALT squashed, stays RUN, Done stays 0.
//  6 Reset mid-RUN -> next cycle IDLE, InstValid=0, ProgCtr=START_ADDR.
//    Start from DONE restarts with CycleCnt=0, Done=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } fetch_state_t;

    // Next-PC source selected by the fetch FSM each cycle.
    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_ABS,
        PC_REL,
        PC_START
    } pc_sel_t;

    localparam logic [8:0] HALT_WORD_DEFAULT = 9'h1FF;

endpackage

// File: rtl/fetch_ctrl_prog_ctr.sv
// Program counter register with its next-PC mux.
// Relative targets are sign-extended offsets of the same width as the PC,
// so a plain A-bit add gives the correct modulo-2^A result.
module prog_ctr
    import fetch_pkg::*;
#(
    parameter int unsigned     A          = 10,
    parameter logic [A-1:0]    START_ADDR = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   sel,
    input  logic [A-1:0] base_pc,
    input  logic [A-1:0] target,
    output logic [A-1:0] pc
);

    logic [A-1:0] pc_q;
    logic [A-1:0] pc_d;

    // Next-PC selection: hold, increment, absolute/relative branch, restart.
    always_comb begin
        pc_d = pc_q;
        case (sel)
            PC_INC:   pc_d = pc_q + A'(1);
            PC_ABS:   pc_d = target;
            PC_REL:   pc_d = base_pc + target;
            PC_START: pc_d = START_ADDR;
            default:  pc_d = pc_q;
        endcase
    end

    // PC register, reloaded with the start address on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= START_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: FSM, registered instruction slot and run-cycle counter.
// The PC itself lives in prog_ctr; this block chooses its next value.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned     A          = 10,
    parameter int unsigned     W          = 9,
    parameter logic [A-1:0]    START_ADDR = '0,
    parameter logic [W-1:0]    HALT_WORD  = W'(HALT_WORD_DEFAULT),
    parameter int unsigned     CW         = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    output logic [A-1:0]  InstAddress,
    input  logic [W-1:0]  InstIn,
    output logic [W-1:0]  Inst,
    output logic          InstValid,
    input  logic          InstReady,
    output logic [A-1:0]  InstPC,
    input  logic          BranchEn,
    input  logic          BranchRel,
    input  logic [A-1:0]  BranchTarget,
    output logic [A-1:0]  ProgCtr,
    output logic          Done,
    output logic [CW-1:0] CycleCnt
);

    fetch_state_t  state_q, state_d;
    logic [W-1:0]  inst_q, inst_d;
    logic [A-1:0]  inst_pc_q, inst_pc_d;
    logic          inst_valid_q, inst_valid_d;
    logic          done_q, done_d;
    logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
    pc_sel_t       pc_sel;
    logic [A-1:0]  pc;
    logic          fire;
    logic          slot_free;

    assign fire      = inst_valid_q & InstReady;
    assign slot_free = ~inst_valid_q | InstReady;

    prog_ctr #(
        .A          (A),
        .START_ADDR (START_ADDR)
    ) u_prog_ctr (
        .clk     (Clk),
        .reset   (Reset),
        .sel     (pc_sel),
        .base_pc (inst_pc_q),
        .target  (BranchTarget),
        .pc      (pc)
    );

    // Next-state logic for the FSM, instruction slot, done flag and counter.
    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        done_d       = done_q;
        cycle_cnt_d  = cycle_cnt_q;
        pc_sel       = PC_HOLD;

        if ((state_q == RUN || state_q == DRAIN) && cycle_cnt_q != '1) begin
            cycle_cnt_d = cycle_cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (Start) begin
                    pc_sel      = PC_START;
                    cycle_cnt_d = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                // A taken branch wins over the same-cycle fetch, squashing it
                // even when the squashed word is the halt word.
                if (fire && BranchEn) begin
                    inst_valid_d = 1'b0;
                    pc_sel       = BranchRel ? PC_REL : PC_ABS;
                end else if (slot_free) begin
                    inst_d       = InstIn;
                    inst_pc_d    = pc;
                    inst_valid_d = 1'b1;
                    pc_sel       = PC_INC;
                    if (InstIn == HALT_WORD) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fire) begin
                    inst_valid_d = 1'b0;
                    if (BranchEn) begin
                        pc_sel  = BranchRel ? PC_REL : PC_ABS;
                        state_d = RUN;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (Start) begin
                    pc_sel      = PC_START;
                    done_d      = 1'b0;
                    cycle_cnt_d = '0;
                    state_d     = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            done_q       <= 1'b0;
            cycle_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            done_q       <= done_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    assign InstAddress = pc;
    assign ProgCtr     = pc;
    assign Inst        = inst_q;
    assign InstPC      = inst_pc_q;
    assign InstValid   = inst_valid_q;
    assign Done        = done_q;
    assign CycleCnt    = cycle_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a ROM model and a fire scoreboard.
module tb_fetch_ctrl;

    localparam logic [8:0] HALT = 9'h1FF;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [9:0]  InstAddress;
    logic [8:0]  InstIn;
    logic [8:0]  Inst;
    logic        InstValid;
    logic        InstReady = 1'b1;
    logic [9:0]  InstPC;
    logic        BranchEn = 1'b0;
    logic        BranchRel = 1'b0;
    logic [9:0]  BranchTarget = '0;
    logic [9:0]  ProgCtr;
    logic        Done;
    logic [15:0] CycleCnt;

    logic [8:0]  rom [0:1023];
    logic [18:0] sb_q [$];
    int          checks = 0;
    int          failures = 0;
    int          path [18] = '{0, 1, 2, 3, 4, 5, 3, 4, 1023, 0, 7, 2, 3, 4, 5, 6, 7, 8};

    assign InstIn = rom[InstAddress];

    always #5 Clk = ~Clk;

    fetch_ctrl #(
        .A  (10),
        .W  (9),
        .CW (16)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .InstAddress  (InstAddress),
        .InstIn       (InstIn),
        .Inst         (Inst),
        .InstValid    (InstValid),
        .InstReady    (InstReady),
        .InstPC       (InstPC),
        .BranchEn     (BranchEn),
        .BranchRel    (BranchRel),
        .BranchTarget (BranchTarget),
        .ProgCtr      (ProgCtr),
        .Done         (Done),
        .CycleCnt     (CycleCnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input int pc);
        sb_q.push_back({pc[9:0], rom[pc]});
    endtask

    // Every consumed instruction must match the next scoreboard entry.
    always @(negedge Clk) begin
        logic [18:0] e;
        if (!Reset && InstValid && InstReady) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                failures++;
                $error("FAIL fire_unexpected observed_pc=%0h expected=none", InstPC);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("fire_pc", {22'd0, InstPC}, {22'd0, e[18:9]});
                chk("fire_inst", {23'd0, Inst}, {23'd0, e[8:0]});
            end
        end
    end

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (Done) break;
            tick();
        end
        chk(tag, {31'd0, Done}, 32'd1);
    endtask

    // Acts as decode: waits for InstPC==pc and takes a branch on that fire.
    task automatic branch_at(input string tag, input int pc, input logic rel,
                             input logic [9:0] tgt, input logic [9:0] exp_pc);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (InstValid && InstPC == pc[9:0]) begin
                found        = 1'b1;
                BranchEn     = 1'b1;
                BranchRel    = rel;
                BranchTarget = tgt;
                tick();
                BranchEn     = 1'b0;
                BranchRel    = 1'b0;
                BranchTarget = '0;
                chk({tag, "_bubble"}, {31'd0, InstValid}, 32'd0);
                tick();
                chk({tag, "_valid"}, {31'd0, InstValid}, 32'd1);
                chk({tag, "_target"}, {22'd0, InstPC}, {22'd0, exp_pc});
            end else begin
                tick();
            end
        end
        chk({tag, "_found"}, {31'd0, found}, 32'd1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
        rom[0] = 9'h001;
        rom[1] = 9'h002;
        rom[2] = HALT;

        // Reset state
        tick();
        tick();
        Reset = 1'b0;
        chk("rst_valid", {31'd0, InstValid}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_cnt", {16'd0, CycleCnt}, 32'd0);
        chk("rst_pc", {22'd0, ProgCtr}, 32'd0);
        chk("rst_inst", {23'd0, Inst}, 32'd0);
        chk("rst_instpc", {22'd0, InstPC}, 32'd0);
        tick();
        chk("idle_pc", {22'd0, ProgCtr}, 32'd0);
        chk("idle_valid", {31'd0, InstValid}, 32'd0);

        // Test 1: straight-line program to halt with InstReady high
        push(0); push(1); push(2);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("t1_addr", {22'd0, InstAddress}, 32'd0);
        chk("t1_novalid", {31'd0, InstValid}, 32'd0);
        tick();
        chk("t1_inst0", {23'd0, Inst}, 32'h001);
        chk("t1_valid0", {31'd0, InstValid}, 32'd1);
        tick();
        chk("t1_inst1", {23'd0, Inst}, 32'h002);
        tick();
        chk("t1_inst2", {23'd0, Inst}, 32'h1FF);
        chk("t1_notdone", {31'd0, Done}, 32'd0);
        tick();
        chk("t1_done", {31'd0, Done}, 32'd1);
        chk("t1_valid_off", {31'd0, InstValid}, 32'd0);
        chk("t1_cnt", {16'd0, CycleCnt}, 32'd4);
        tick();
        chk("t1_cnt_hold", {16'd0, CycleCnt}, 32'd4);
        chk("t1_sb_empty", sb_q.size(), 32'd0);

        // Test 2: restart from DONE, then stall three cycles on the first word
        push(0); push(1); push(2);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("t2_cnt_clr", {16'd0, CycleCnt}, 32'd0);
        chk("t2_done_clr", {31'd0, Done}, 32'd0);
        chk("t2_pc_start", {22'd0, ProgCtr}, 32'd0);
        tick();
        InstReady = 1'b0;
        chk("t2_inst0", {23'd0, Inst}, 32'h001);
        chk("t2_pc1", {22'd0, ProgCtr}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t2_stall_inst", {23'd0, Inst}, 32'h001);
            chk("t2_stall_pc", {22'd0, ProgCtr}, 32'd1);
            chk("t2_stall_valid", {31'd0, InstValid}, 32'd1);
        end
        tick();
        chk("t2_stall_inst_last", {23'd0, Inst}, 32'h001);
        chk("t2_stall_pc_last", {22'd0, ProgCtr}, 32'd1);
        InstReady = 1'b1;
        wait_done("t2_done", 20);
        chk("t2_cnt", {16'd0, CycleCnt}, 32'd7);
        chk("t2_sb_empty", sb_q.size(), 32'd0);

        // Tests 3-5: relative branch, absolute branch with wrap, branch over halt
        for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
        for (int i = 0; i < 8; i++) rom[i] = 9'h010 + 9'(i);
        rom[8]    = HALT;
        rom[1023] = 9'h0AA;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 18; i++) push(path[i]);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        branch_at("t3_rel", 5, 1'b1, 10'h3FE, 10'h003);
        branch_at("t4_abs", 4, 1'b0, 10'h3FF, 10'h3FF);
        branch_at("t4_wrap", 0, 1'b0, 10'h007, 10'h007);
        branch_at("t5_halt_squash", 7, 1'b0, 10'h002, 10'h002);
        chk("t5_notdone", {31'd0, Done}, 32'd0);
        wait_done("t5_done", 30);
        chk("t5_sb_empty", sb_q.size(), 32'd0);

        // Test 6: counter saturation during a long stall, then reset mid-RUN
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        InstReady = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 65540; i++) tick();
        chk("t6_cnt_sat", {16'd0, CycleCnt}, 32'h0000FFFF);
        chk("t6_held_inst", {23'd0, Inst}, 32'h010);
        chk("t6_held_pc", {22'd0, ProgCtr}, 32'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        InstReady = 1'b1;
        chk("t6_rst_valid", {31'd0, InstValid}, 32'd0);
        chk("t6_rst_pc", {22'd0, ProgCtr}, 32'd0);
        chk("t6_rst_cnt", {16'd0, CycleCnt}, 32'd0);
        chk("t6_rst_done", {31'd0, Done}, 32'd0);
        tick();
        chk("t6_idle_pc", {22'd0, ProgCtr}, 32'd0);
        chk("t6_idle_valid", {31'd0, InstValid}, 32'd0);
        chk("t6_idle_cnt", {16'd0, CycleCnt}, 32'd0);
        chk("t6_sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
